hamming_serial_rx: RTL and testbench
====================================

# hamming_serial_rx

Serial receive end of the team's Hamming-protected 8-bit shift-register path. The block deserialises a 13-bit SECDED Hamming(13,8) codeword arriving one bit per enabled clock on `serial_in`, then decodes it. It corrects any single-bit error, flags double-bit errors, and presents the 8-bit data word with a valid/ready handshake. It sits downstream of the protected register's `serial_out`.

## Interface
- `DATA_W`, 8: data width; fixed at 8, present for package consistency only.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  bit strobe; `serial_in` is sampled only when high.
- `start`  in  1  frame marker; qualified by `enable`, marks codeword bit 0.
- `serial_in`  in  1  serial codeword bit.
- `data_out`  out  8  decoded (corrected) data.
- `data_valid`  out  1  `data_out` and flags are valid.
- `data_ready`  in  1  consumer accepts the word.
- `single_err`  out  1  single error detected and corrected.
- `double_err`  out  1  uncorrectable error detected.
- `syndrome`  out  4  raw syndrome of the delivered word.
- `busy`  out  1  frame in progress (SHIFT or DECODE).
- `overrun`  out  1  one-cycle pulse when a decoded word is dropped.

## Operation
- Codeword bit i is Hamming position i, for i = 0..12.
- Position 0 is the overall parity p0. Positions 1, 2, 4 and 8 are p1, p2, p4 and p8.
- Positions 3, 5, 6, 7, 9, 10, 11 and 12 carry d0..d7.
- Bits are transmitted in position order, 0 first and 12 last.
- FSM states are IDLE, SHIFT and DECODE.
  - IDLE: `enable && start` captures bit 0, sets the counter to 1 and moves to SHIFT. `start` without `enable` is ignored.
  - SHIFT: each `enable` cycle captures the bit at the counter position and increments the counter. `enable` low stalls the state and the counter. Capturing bit 12 moves to DECODE.
  - SHIFT, restart: `enable && start` restarts the frame by capturing bit 0, setting the counter to 1 and staying in SHIFT. No flag is raised.
  - DECODE: a single cycle, then an unconditional move to IDLE.
- Decode rules. Syndrome s = XOR of the indices of all set bits in positions 1..12. Overall parity P = XOR of all 13 bits.
  - s=0, P=0: clean word; both error flags are 0.
  - s≠0, P=1, s≤12: the bit at position s is flipped and `single_err`=1.
  - s=0, P=1: the error is in p0, data is untouched and `single_err`=1.
  - s≠0, P=0: `double_err`=1 and raw data is delivered.
  - s>12, any P: `double_err`=1 and raw data is delivered.
- Output register. DECODE loads `data_out`, `single_err`, `double_err` and `syndrome`, and sets `data_valid`. The load is blocked only when `data_valid && !data_ready` in that cycle. In the blocked case the new word is dropped and `overrun` pulses.
- Simultaneous accept and load (`data_valid && data_ready` in the DECODE cycle): the old word is consumed, the new word is loaded and `data_valid` stays 1.
- Handshake: a word transfers on any edge with `data_valid && data_ready`. With no new load, `data_valid` then clears. While `data_valid` is high, `data_out` and the flags are stable.
- Reset (including mid-frame): state IDLE; counter, shift register, `data_out`, `syndrome` and all flags cleared; `data_valid`, `busy` and `overrun` are 0. A partial frame is discarded.

## Timing
- Bit 12 is captured at edge k. DECODE occupies cycle k→k+1. `data_valid` is high after edge k+1.
- Latency is 1 clock from the last-bit capture.
- Minimum frame is 13 enabled cycles plus 1 decode cycle.
- A new frame may start in the DECODE cycle's successor, giving back-to-back throughput of 1 word per 14 clocks.
- `busy` is high from the edge that captures bit 0 through the end of DECODE.
- `overrun` is registered and high for exactly one cycle after the blocked DECODE.

## Structure
- `hamming_pkg` holds the shared definitions:
  - `CODE_W`=13 and `DATA_W`=8.
  - The `codeword_t` typedef, `logic [12:0]`.
  - The `rx_state_t` enum.
  - The data-position constant list.
- `hamming_pkg` is shared with the encoder side of the protected register.
- One combinational sub-module, `hamming_secded_dec`: codeword in; corrected data, syndrome, `single_err` and `double_err` out.
- FSM, counter, shift register and output register live in `hamming_serial_rx`.

## Test plan
- Reset, then send 0x144E (data 0xA5) with `data_ready`=1 → `data_out`=0xA5, no error flags, `syndrome`=0, `data_valid` high 1 clock after bit 12.
- 0x144E with position 6 flipped (0x140E) → `data_out`=0xA5, `single_err`=1, `syndrome`=6.
- 0x144E with position 0 flipped (0x144F) → `data_out`=0xA5, `single_err`=1, `syndrome`=0.
- 0x144E with positions 3 and 5 flipped → `double_err`=1, `syndrome`=6, raw data delivered (not 0xA5).
- Hold `data_ready`=0 through two full frames → first word held stable, `overrun` pulses once, then `data_ready`=1 delivers the first word.
- Stall `enable` mid-frame for 5 cycles, then assert `rst` mid-frame and resend → the stall does not corrupt the frame, reset clears all outputs, and the next frame decodes 0xA5.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(13,8) SECDED definitions, used by both the encoder side of
// the protected register and the serial receiver.
//   CODE_W   : codeword width (positions 0..12, position 0 is overall parity)
//   DATA_W   : data width
//   codeword_t, rx_state_t, DATA_POS (codeword position of data bit i)
package hamming_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;

    typedef logic [CODE_W-1:0] codeword_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } rx_state_t;

    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational Hamming(13,8) SECDED decoder.
//   codeword   in  13  received codeword, bit i = Hamming position i
//   data       out 8   corrected data (raw data on double error)
//   syndrome   out 4   XOR of indices of set bits in positions 1..12
//   single_err out 1   single error corrected (includes error in p0)
//   double_err out 1   uncorrectable error
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [DATA_W-1:0] data,
    output logic [3:0]        syndrome,
    output logic              single_err,
    output logic              double_err
);

    logic      parity;
    codeword_t fixed;

    always_comb begin
        syndrome   = '0;
        parity     = ^codeword;
        fixed      = codeword;
        single_err = 1'b0;
        double_err = 1'b0;
        data       = '0;

        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (codeword[i]) begin
                syndrome = syndrome ^ 4'(i);
            end
        end

        // Syndromes 13..15 point outside the codeword, so they can only come
        // from multiple errors regardless of overall parity.
        if (syndrome == 4'd0) begin
            single_err = parity;
        end else if (syndrome > 4'd12) begin
            double_err = 1'b1;
        end else if (parity) begin
            fixed[syndrome] = ~fixed[syndrome];
            single_err      = 1'b1;
        end else begin
            double_err = 1'b1;
        end

        for (int unsigned i = 0; i < DATA_W; i++) begin
            data[i] = fixed[DATA_POS[i]];
        end
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial receiver for Hamming(13,8) SECDED codewords. Deserialises 13 bits
// (position 0 first) on enabled clocks, decodes in one cycle, and holds the
// result in a valid/ready output register.
//   clk, rst              clock, asynchronous active-high reset
//   enable, start         bit strobe, frame marker (bit 0) qualified by enable
//   serial_in             serial codeword bit
//   data_out, syndrome    decoded data and raw syndrome of delivered word
//   single_err, double_err error flags of delivered word
//   data_valid/data_ready output handshake
//   busy                  frame in progress (SHIFT or DECODE)
//   overrun               one-cycle pulse when a decoded word is dropped
module hamming_serial_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              single_err,
    output logic              double_err,
    output logic [3:0]        syndrome,
    output logic              busy,
    output logic              overrun
);

    import hamming_pkg::*;

    rx_state_t   state, state_n;
    logic [3:0]  cnt, cnt_n;
    codeword_t   sreg, sreg_n;
    logic        load;

    logic [7:0]  dec_data;
    logic [3:0]  dec_syn;
    logic        dec_single;
    logic        dec_double;

    hamming_secded_dec u_dec (
        .codeword   (sreg),
        .data       (dec_data),
        .syndrome   (dec_syn),
        .single_err (dec_single),
        .double_err (dec_double)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        load    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable && start) begin
                    sreg_n    = '0;
                    sreg_n[0] = serial_in;
                    cnt_n     = 4'd1;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    // A start strobe mid-frame abandons the partial codeword.
                    if (start) begin
                        sreg_n    = '0;
                        sreg_n[0] = serial_in;
                        cnt_n     = 4'd1;
                    end else begin
                        sreg_n[cnt] = serial_in;
                        if (cnt == 4'd12) begin
                            cnt_n   = '0;
                            state_n = ST_DECODE;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end
                end
            end
            ST_DECODE: begin
                load    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            syndrome   <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (data_valid && !data_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out   <= dec_data;
                    syndrome   <= dec_syn;
                    single_err <= dec_single;
                    double_err <= dec_double;
                    data_valid <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
module tb_hamming_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       single_err;
    logic       double_err;
    logic [3:0] syndrome;
    logic       busy;
    logic       overrun;

    int compared   = 0;
    int mismatched = 0;
    int ov_cnt     = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       se;
        logic       de;
    } ref_t;

    hamming_serial_rx #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start      (start),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .single_err (single_err),
        .double_err (double_err),
        .syndrome   (syndrome),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun === 1'b1) ov_cnt++;

    // Reference decoder: straight from the positional rules of the code.
    function automatic ref_t ref_decode(input logic [12:0] cw);
        int pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        int s = 0;
        int ones = 0;
        logic [12:0] c = cw;
        ref_t r;
        for (int i = 1; i < 13; i++) if (cw[i]) s = s ^ i;
        for (int i = 0; i < 13; i++) if (cw[i]) ones++;
        r.se = 1'b0;
        r.de = 1'b0;
        if (s == 0) begin
            r.se = (ones % 2 == 1);
        end else if (s <= 12 && ones % 2 == 1) begin
            c[s] = ~c[s];
            r.se = 1'b1;
        end else begin
            r.de = 1'b1;
        end
        r.syn = 4'(s);
        for (int i = 0; i < 8; i++) r.data[i] = c[pos[i]];
        return r;
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] d);
        int pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [12:0] cw = '0;
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            cw[pos[i]] = d[i];
            if (d[i]) s = s ^ pos[i];
        end
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the 13 bits; returns at the negedge after bit 12 was captured
    // (the DECODE cycle), with enable released.
    task automatic send_frame(input logic [12:0] cw, input int stall_after, input int stall_len);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            enable    = 1'b1;
            start     = (i == 0);
            serial_in = cw[i];
            if (i == stall_after) begin
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    enable    = 1'b0;
                    start     = 1'($urandom_range(0, 1));
                    serial_in = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                enable    = 1'b1;
                start     = 1'b0;
                serial_in = cw[i + 1];
                i++;
            end
        end
        @(negedge clk);
        enable    = 1'b0;
        start     = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic check_word(input string tag, input ref_t e);
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_data"},  32'(data_out),   32'(e.data));
        check({tag, "_syn"},   32'(syndrome),   32'(e.syn));
        check({tag, "_se"},    32'(single_err), 32'(e.se));
        check({tag, "_de"},    32'(double_err), 32'(e.de));
    endtask

    initial begin
        ref_t       e;
        logic [12:0] cw;
        logic [7:0]  d;
        int          nflip;
        int          p1, p2;

        rst        = 1'b1;
        enable     = 1'b0;
        start      = 1'b0;
        serial_in  = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_data",  32'(data_out),   32'd0);
        check("rst_ovr",   32'(overrun),    32'd0);
        rst = 1'b0;

        // start without enable is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_no_en_busy", 32'(busy), 32'd0);

        // clean word, latency
        send_frame(13'h144E, -1, 0);
        check("clean_busy_decode", 32'(busy),       32'd1);
        check("clean_lat_valid0",  32'(data_valid), 32'd0);
        @(negedge clk);
        e.data = 8'hA5; e.syn = 4'd0; e.se = 1'b0; e.de = 1'b0;
        check_word("clean", e);
        check("clean_busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("clean_consumed", 32'(data_valid), 32'd0);

        // single error at position 6
        send_frame(13'h140E, -1, 0);
        @(negedge clk);
        e.data = 8'hA5; e.syn = 4'd6; e.se = 1'b1; e.de = 1'b0;
        check_word("single6", e);

        // single error in p0
        send_frame(13'h144F, -1, 0);
        @(negedge clk);
        e.data = 8'hA5; e.syn = 4'd0; e.se = 1'b1; e.de = 1'b0;
        check_word("single0", e);

        // double error at positions 3 and 5
        send_frame(13'h144E ^ 13'h0028, -1, 0);
        @(negedge clk);
        e.data = 8'hA6; e.syn = 4'd6; e.se = 1'b0; e.de = 1'b1;
        check_word("double35", e);

        // restart mid-frame: 5 junk bits then a full frame beginning with start
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enable    = 1'b1;
            start     = (i == 0);
            serial_in = 1'b1;
        end
        send_frame(13'h144E, -1, 0);
        @(negedge clk);
        e.data = 8'hA5; e.syn = 4'd0; e.se = 1'b0; e.de = 1'b0;
        check_word("restart", e);

        // backpressure: two frames with data_ready low
        @(negedge clk);
        data_ready = 1'b0;
        ov_cnt     = 0;
        send_frame(13'h144E, -1, 0);
        @(negedge clk);
        send_frame(encode(8'h3C), -1, 0);
        @(negedge clk);
        check("bp_overrun_pulse", 32'(overrun),    32'd1);
        check("bp_hold_valid",    32'(data_valid), 32'd1);
        check("bp_hold_data",     32'(data_out),   32'hA5);
        @(negedge clk);
        check("bp_overrun_once",  32'(ov_cnt),     32'd1);
        check("bp_overrun_low",   32'(overrun),    32'd0);
        check("bp_still_data",    32'(data_out),   32'hA5);
        data_ready = 1'b1;
        @(negedge clk);
        check("bp_delivered", 32'(data_valid), 32'd0);

        // stall enable 5 cycles mid-frame, hold the word with data_ready low
        data_ready = 1'b0;
        send_frame(13'h144E, 6, 5);
        @(negedge clk);
        e.data = 8'hA5; e.syn = 4'd0; e.se = 1'b0; e.de = 1'b0;
        check_word("stall", e);

        // reset mid-frame
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            enable    = 1'b1;
            start     = (i == 0);
            serial_in = 1'b1;
        end
        @(negedge clk);
        enable = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_busy",  32'(busy),       32'd0);
        check("rst_async_valid", 32'(data_valid), 32'd0);
        check("rst_async_data",  32'(data_out),   32'd0);
        check("rst_async_syn",   32'(syndrome),   32'd0);
        @(negedge clk);
        rst        = 1'b0;
        data_ready = 1'b1;
        send_frame(13'h144E, -1, 0);
        @(negedge clk);
        check_word("post_rst", e);

        // randomized frames with 0, 1 or 2 bit flips against the reference
        for (int t = 0; t < 40; t++) begin
            d     = 8'($urandom);
            cw    = encode(d);
            nflip = $urandom_range(0, 2);
            p1    = $urandom_range(0, 12);
            p2    = (p1 + $urandom_range(1, 12)) % 13;
            if (nflip >= 1) cw[p1] = ~cw[p1];
            if (nflip == 2) cw[p2] = ~cw[p2];
            send_frame(cw, (t % 3 == 0) ? int'($urandom_range(0, 11)) : -1, $urandom_range(1, 4));
            @(negedge clk);
            e = ref_decode(cw);
            check_word("rand", e);
            if (nflip < 2) check("rand_orig_data", 32'(data_out), 32'(d));
            check("rand_flags", 32'({single_err, double_err}),
                  (nflip == 0) ? 32'd0 : (nflip == 1) ? 32'd2 : 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
